// File: rtl/acq_seq_if.sv
// Capture sequencer bundle: host config, trigger/decimator inputs, decimator control and
// sample RAM write port.
interface acq_seq_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned NUM_W  = 16
);
  logic              start;
  logic              abort;
  logic [NUM_W-1:0]  cfg_num;
  logic              cfg_div2;
  logic [ADDR_W-1:0] cfg_pre;
  logic [ADDR_W-1:0] cfg_post;
  logic              trig;
  logic              deci_out;
  logic              deci_en;
  logic              deci_div2;
  logic [NUM_W-1:0]  deci_num;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] trig_addr;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, cfg_num, cfg_div2, cfg_pre, cfg_post, trig, deci_out,
    input  deci_en, deci_div2, deci_num, wr_en, wr_addr, trig_addr, busy, done
  );

  modport slave (
    input  start, abort, cfg_num, cfg_div2, cfg_pre, cfg_post, trig, deci_out,
    output deci_en, deci_div2, deci_num, wr_en, wr_addr, trig_addr, busy, done
  );
endinterface

// File: rtl/acq_seq.sv
// Acquisition sequencer: pre-trigger fill, armed wait, post-trigger count into a circular
// sample buffer, driving the decimator from a latched copy of the host config.
module acq_seq #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned NUM_W  = 16
) (
  input logic      clk,
  input logic      nrst,
  acq_seq_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StPre, StArm, StPost, StDone} state_e;

  state_e            state_q;
  logic [NUM_W-1:0]  cfg_num_q;
  logic              cfg_div2_q;
  logic [ADDR_W-1:0] cfg_pre_q;
  logic [ADDR_W-1:0] cfg_post_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              trig_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] trig_addr_q;

  logic              active;
  logic              fire;
  logic              take;
  logic [ADDR_W-1:0] cnt_inc;
  logic              post_hit;

  assign active  = (state_q == StPre) || (state_q == StArm) || (state_q == StPost);
  assign fire    = (state_q == StArm) && bus.trig && !trig_q;
  assign cnt_inc = cnt_q + ADDR_W'(1);

  // A zero post count means nothing may be written once the trigger fires.
  always_comb begin
    take = 1'b0;
    if (!bus.abort && active && bus.deci_out) begin
      take = !(fire && (cfg_post_q == '0));
    end
  end

  always_comb begin
    post_hit = (cfg_post_q == '0);
    if (take) begin
      post_hit = (cfg_post_q == ADDR_W'(1));
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      cfg_num_q   <= '0;
      cfg_div2_q  <= 1'b0;
      cfg_pre_q   <= '0;
      cfg_post_q  <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      trig_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
    end else begin
      trig_q  <= bus.trig;
      wr_en_q <= take;
      if (take) begin
        wr_addr_q <= ptr_q;
        ptr_q     <= ptr_q + ADDR_W'(1);
      end

      if (bus.abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (bus.start) begin
              cfg_num_q  <= bus.cfg_num;
              cfg_div2_q <= bus.cfg_div2;
              cfg_pre_q  <= bus.cfg_pre;
              cfg_post_q <= bus.cfg_post;
              ptr_q      <= '0;
              cnt_q      <= '0;
              state_q    <= StPre;
            end
          end
          StPre: begin
            if (take) begin
              cnt_q <= cnt_inc;
            end
            if ((cnt_q == cfg_pre_q) || (take && (cnt_inc == cfg_pre_q))) begin
              cnt_q   <= '0;
              state_q <= StArm;
            end
          end
          StArm: begin
            if (fire) begin
              trig_addr_q <= ptr_q;
              cnt_q       <= take ? ADDR_W'(1) : '0;
              state_q     <= post_hit ? StDone : StPost;
            end
          end
          StPost: begin
            if (take) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == cfg_post_q) begin
                state_q <= StDone;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.deci_en   = active;
  assign bus.busy      = active;
  assign bus.done      = (state_q == StDone);
  assign bus.deci_num  = cfg_num_q;
  assign bus.deci_div2 = cfg_div2_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.trig_addr = trig_addr_q;

endmodule

// File: tb/tb_acq_seq.sv
// Directed bench for acq_seq: expected RAM writes go into per-instance queues and are
// popped by monitors whenever wr_en is seen; status outputs are checked at fixed points.
module tb_acq_seq;

  logic clk;
  logic nrst;

  acq_seq_if #(.ADDR_W(10), .NUM_W(16)) b10 ();
  acq_seq_if #(.ADDR_W(3),  .NUM_W(16)) b3 ();

  acq_seq #(.ADDR_W(10), .NUM_W(16)) u_dut10 (.clk(clk), .nrst(nrst), .bus(b10));
  acq_seq #(.ADDR_W(3),  .NUM_W(16)) u_dut3  (.clk(clk), .nrst(nrst), .bus(b3));

  int total = 0;
  int bad   = 0;
  int q10[$];
  int q3[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (b10.wr_en === 1'b1) begin
      if (q10.size() == 0) check("unexpected_wr10", 32'(b10.wr_addr), 32'hffff_ffff);
      else check("wr_addr10", 32'(b10.wr_addr), 32'(q10.pop_front()));
    end
    if (b3.wr_en === 1'b1) begin
      if (q3.size() == 0) check("unexpected_wr3", 32'(b3.wr_addr), 32'hffff_ffff);
      else check("wr_addr3", 32'(b3.wr_addr), 32'(q3.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start10(input int num, input bit div2, input int pre, input int post);
    b10.cfg_num  = 16'(num);
    b10.cfg_div2 = div2;
    b10.cfg_pre  = 10'(pre);
    b10.cfg_post = 10'(post);
    b10.start    = 1'b1;
    tick(1);
    b10.start    = 1'b0;
  endtask

  task automatic start3(input int pre, input int post);
    b3.cfg_num  = 16'd1;
    b3.cfg_pre  = 3'(pre);
    b3.cfg_post = 3'(post);
    b3.start    = 1'b1;
    tick(1);
    b3.start    = 1'b0;
  endtask

  task automatic samp10(input int addr, input bit exp_wr);
    if (exp_wr) q10.push_back(addr);
    b10.deci_out = 1'b1;
    tick(1);
    b10.deci_out = 1'b0;
    tick(5);
  endtask

  task automatic samp3(input int addr);
    q3.push_back(addr);
    b3.deci_out = 1'b1;
    tick(1);
    b3.deci_out = 1'b0;
    tick(5);
  endtask

  task automatic fire10();
    b10.trig = 1'b1;
    tick(1);
    b10.trig = 1'b0;
    tick(1);
  endtask

  initial begin
    nrst = 1'b0;
    {b10.start, b10.abort, b10.cfg_div2, b10.trig, b10.deci_out} = '0;
    b10.cfg_num = '0; b10.cfg_pre = '0; b10.cfg_post = '0;
    {b3.start, b3.abort, b3.cfg_div2, b3.trig, b3.deci_out} = '0;
    b3.cfg_num = '0; b3.cfg_pre = '0; b3.cfg_post = '0;
    tick(2);
    check("rst_outputs10", {b10.deci_en, b10.busy, b10.done, b10.wr_en, b10.deci_div2},
          32'd0);
    check("rst_done3", 32'(b3.done), 32'd0);
    nrst = 1'b1;
    tick(1);

    // Reset asserted in the middle of a capture clears everything at once.
    start10(3, 1'b1, 8, 2);
    samp10(0, 1'b1);
    samp10(1, 1'b1);
    check("pre_rst_div2", 32'(b10.deci_div2), 32'd1);
    check("pre_rst_wr_addr", 32'(b10.wr_addr), 32'd1);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    check("async_rst_outs", {b10.deci_en, b10.busy, b10.done, b10.wr_en, b10.deci_div2},
          32'd0);
    check("async_rst_addr", {b10.deci_num, 6'(b10.wr_addr), 6'(b10.trig_addr)}, 32'd0);
    tick(2);
    nrst = 1'b1;
    tick(1);
    check("post_rst_idle", {b10.deci_en, b10.busy}, 32'd0);

    // Normal capture; a start while busy must be ignored.
    start10(5, 1'b0, 4, 3);
    check("run_en_busy", {b10.deci_en, b10.busy, b10.done}, 32'b110);
    check("run_num", 32'(b10.deci_num), 32'd5);
    samp10(0, 1'b1);
    samp10(1, 1'b1);
    start10(9, 1'b1, 1, 1);
    check("busy_start_num", 32'(b10.deci_num), 32'd5);
    for (int i = 2; i < 6; i++) samp10(i, 1'b1);
    fire10();
    check("trig_addr_norm", 32'(b10.trig_addr), 32'd6);
    for (int i = 6; i < 9; i++) samp10(i, 1'b1);
    check("norm_done", {b10.deci_en, b10.busy, b10.done}, 32'b001);
    samp10(0, 1'b0);
    check("norm_hold", {22'(b10.trig_addr), 10'(b10.wr_addr)}, {22'd6, 10'd8});

    // Restart from DONE; trigger in PRE ignored, level held into ARM does not fire.
    start10(7, 1'b0, 4, 2);
    check("restart_num", 32'(b10.deci_num), 32'd7);
    samp10(0, 1'b1);
    samp10(1, 1'b1);
    fire10();
    samp10(2, 1'b1);
    b10.trig = 1'b1;
    samp10(3, 1'b1);
    samp10(4, 1'b1);
    check("held_no_fire", {29'(b10.trig_addr), b10.busy, b10.done}, {29'd6, 2'b10});
    b10.trig = 1'b0;
    tick(1);
    fire10();
    check("trig_addr_refire", 32'(b10.trig_addr), 32'd5);
    samp10(5, 1'b1);
    check("post1_not_done", 32'(b10.done), 32'd0);
    samp10(6, 1'b1);
    check("refire_done", 32'(b10.done), 32'd1);

    // Trigger edge coincident with a sample: that sample is post #1.
    start10(2, 1'b0, 1, 2);
    samp10(0, 1'b1);
    q10.push_back(1);
    b10.trig = 1'b1;
    b10.deci_out = 1'b1;
    tick(1);
    b10.trig = 1'b0;
    b10.deci_out = 1'b0;
    check("coinc_trig_addr", 32'(b10.trig_addr), 32'd1);
    tick(5);
    check("coinc_not_done", 32'(b10.done), 32'd0);
    samp10(2, 1'b1);
    check("coinc_done", 32'(b10.done), 32'd1);

    // Abort in POST: pending write completes, further sample and start are dropped.
    start10(11, 1'b0, 2, 4);
    samp10(0, 1'b1);
    samp10(1, 1'b1);
    fire10();
    samp10(2, 1'b1);
    q10.push_back(3);
    b10.deci_out = 1'b1;
    tick(1);
    b10.abort = 1'b1;
    b10.start = 1'b1;
    tick(1);
    b10.abort = 1'b0;
    b10.start = 1'b0;
    b10.deci_out = 1'b0;
    check("abort_idle", {b10.deci_en, b10.busy, b10.done}, 32'd0);
    tick(4);
    check("abort_hold", {16'(b10.trig_addr), b10.deci_num}, {16'd2, 16'd11});
    start10(13, 1'b0, 1, 1);
    check("abort_restart_num", 32'(b10.deci_num), 32'd13);
    samp10(0, 1'b1);
    fire10();
    samp10(1, 1'b1);
    check("abort_restart_done", 32'(b10.done), 32'd1);

    // Small buffer: pointer wraps; then zero pre/post counts.
    start3(6, 5);
    for (int i = 0; i < 6; i++) samp3(i);
    b3.trig = 1'b1;
    tick(1);
    b3.trig = 1'b0;
    tick(1);
    check("wrap_trig_addr", 32'(b3.trig_addr), 32'd6);
    for (int i = 6; i < 11; i++) samp3(i % 8);
    check("wrap_done", {b3.deci_en, b3.done}, 32'b01);
    start3(0, 0);
    tick(1);
    check("zero_armed", {b3.busy, b3.done}, 32'b10);
    b3.trig = 1'b1;
    b3.deci_out = 1'b1;
    tick(1);
    b3.trig = 1'b0;
    b3.deci_out = 1'b0;
    check("zero_done", {b3.busy, b3.done}, 32'b01);
    check("zero_trig_addr", 32'(b3.trig_addr), 32'd0);
    tick(3);

    check("q10_drained", 32'(q10.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
